// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that shares one cache-line-wide memory interface
// between the instruction cache (port 0) and the data cache (port 1).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [DATA_W-1:0] req0_data_o,

  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [DATA_W-1:0] req1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,

  output logic [1:0]        grant_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q;
  logic   last_q;
  logic   pick1;

  // Port 1 wins when alone, or when both request and port 0 won last time.
  always_comb begin
    pick1 = req1_enable_i && (!req0_enable_i || !last_q);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_q       <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      grant_o      <= '0;
      busy_o       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0_enable_i || req1_enable_i) begin
            mem_enable_o <= 1'b1;
            busy_o       <= 1'b1;
            last_q       <= pick1;
            if (pick1) begin
              state_q     <= GRANT1;
              grant_o     <= 2'b10;
              mem_write_o <= req1_write_i;
              mem_addr_o  <= req1_addr_i;
              mem_data_o  <= req1_data_i;
            end else begin
              state_q     <= GRANT0;
              grant_o     <= 2'b01;
              mem_write_o <= req0_write_i;
              mem_addr_o  <= req0_addr_i;
              mem_data_o  <= req0_data_i;
            end
          end
        end
        GRANT0, GRANT1: begin
          if (mem_ack_i) begin
            state_q      <= DONE;
            mem_enable_o <= 1'b0;
            grant_o      <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    req0_ack_o  = mem_ack_i && (state_q == GRANT0);
    req1_ack_o  = mem_ack_i && (state_q == GRANT1);
    req0_data_o = req0_ack_o ? mem_data_i : '0;
    req1_data_o = req1_ack_o ? mem_data_i : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of ownership and round-robin turns.
module tb_mem_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req0_enable_i, req0_write_i;
  logic [31:0]  req0_addr_i;
  logic [255:0] req0_data_i;
  logic         req0_ack_o;
  logic [255:0] req0_data_o;
  logic         req1_enable_i, req1_write_i;
  logic [31:0]  req1_addr_i;
  logic [255:0] req1_data_i;
  logic         req1_ack_o;
  logic [255:0] req1_data_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;
  logic [1:0]   grant_o;
  logic         busy_o;

  mem_arbiter #(.ADDR_W(32), .DATA_W(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
    .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
    .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
    .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: which port owns memory (-1 none), whether the post-ack bubble is
  // pending, who won last, and the transaction captured at grant time.
  int           m_owner;
  bit           m_bubble;
  int           m_last;
  logic         m_write;
  logic [31:0]  m_addr;
  logic [255:0] m_data;

  logic [1:0]   prev_grant = '0;
  logic [1:0]   obs_q[$];
  bit           acked0, acked1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_reset();
    m_owner  = -1;
    m_bubble = 1'b0;
    m_last   = 0;
    m_write  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endfunction

  function automatic void model_edge();
    int w;
    if (m_owner >= 0) begin
      if (mem_ack_i) begin
        m_owner  = -1;
        m_bubble = 1'b1;
      end
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (req0_enable_i || req1_enable_i) begin
      if (req0_enable_i && req1_enable_i) w = 1 - m_last;
      else w = req1_enable_i ? 1 : 0;
      m_last  = w;
      m_owner = w;
      m_write = (w == 1) ? req1_write_i : req0_write_i;
      m_addr  = (w == 1) ? req1_addr_i  : req0_addr_i;
      m_data  = (w == 1) ? req1_data_i  : req0_data_i;
    end
  endfunction

  // Inputs are set by the caller just after a rising edge; outputs compared on
  // the falling edge; model advanced on the next rising edge.
  task automatic cycle();
    logic [1:0] eg;
    logic       ea0, ea1;
    if (!rst_i) model_reset();
    @(negedge clk_i);
    eg  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    ea0 = mem_ack_i && (m_owner == 0);
    ea1 = mem_ack_i && (m_owner == 1);
    check("grant",    grant_o,      eg);
    check("busy",     busy_o,       (m_owner >= 0) || m_bubble);
    check("mem_en",   mem_enable_o, m_owner >= 0);
    check("mem_wr",   mem_write_o,  m_write);
    check("mem_addr", mem_addr_o,   m_addr);
    check("mem_data", mem_data_o,   m_data);
    check("ack0",     req0_ack_o,   ea0);
    check("ack1",     req1_ack_o,   ea1);
    check("rdata0",   req0_data_o,  ea0 ? mem_data_i : 256'd0);
    check("rdata1",   req1_data_o,  ea1 ? mem_data_i : 256'd0);
    if (grant_o != 2'b00 && prev_grant == 2'b00) obs_q.push_back(grant_o);
    prev_grant = grant_o;
    acked0 = ea0;
    acked1 = ea1;
    @(posedge clk_i);
    if (!rst_i) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (m_owner < 0 && n < 30) begin
      cycle();
      n++;
    end
    check("wait_grant", mem_enable_o, 1'b1);
  endtask

  task automatic serve(input int lat, input logic [255:0] data);
    repeat (lat) begin
      mem_ack_i  = 1'b0;
      mem_data_i = rand256();
      cycle();
    end
    mem_ack_i  = 1'b1;
    mem_data_i = data;
    cycle();
    mem_ack_i  = 1'b0;
    mem_data_i = rand256();
  endtask

  task automatic pulse_reset();
    rst_i = 1'b0;
    cycle();
    rst_i = 1'b1;
  endtask

  initial begin
    logic [255:0] pat_a, pat_b;
    pat_a = {8{32'hA5A5_0F0F}};
    pat_b = {8{32'h1234_BEEF}};
    model_reset();

    // Reset held with random inputs, then release with no requests.
    rst_i = 1'b0;
    repeat (5) begin
      req0_enable_i = 1'($urandom); req0_write_i = 1'($urandom);
      req0_addr_i = $urandom; req0_data_i = rand256();
      req1_enable_i = 1'($urandom); req1_write_i = 1'($urandom);
      req1_addr_i = $urandom; req1_data_i = rand256();
      mem_ack_i = 1'($urandom); mem_data_i = rand256();
      cycle();
    end
    rst_i = 1'b1;
    req0_enable_i = 1'b0; req1_enable_i = 1'b0; mem_ack_i = 1'b0;
    repeat (6) cycle();

    // Single port-0 read, memory answers after 10 cycles.
    req0_enable_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h0000_0400;
    cycle();
    check("t_read_addr", mem_addr_o, 32'h400);
    serve(10, pat_a);
    req0_enable_i = 1'b0;
    repeat (3) cycle();

    // Contention right after reset: port 1 first, then strict alternation.
    pulse_reset();
    req0_enable_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h100; req0_data_i = rand256();
    req1_enable_i = 1'b1; req1_write_i = 1'b1; req1_addr_i = 32'h200; req1_data_i = pat_b;
    obs_q.delete();
    for (int t = 0; t < 4; t++) begin
      wait_grant();
      if (t == 0) check("t_first_data", mem_data_o, pat_b);
      serve(int'($urandom_range(1, 4)), rand256());
    end
    check("t_rr_count", obs_q.size(), 4);
    for (int t = 0; t < 4 && t < obs_q.size(); t++)
      check("t_rr_order", obs_q[t], (t % 2 == 0) ? 2'b10 : 2'b01);
    req0_enable_i = 1'b0; req1_enable_i = 1'b0;
    repeat (3) cycle();

    // Requester changes address and drops enable mid-grant.
    req1_enable_i = 1'b1; req1_write_i = 1'b1; req1_addr_i = 32'h200;
    wait_grant();
    req1_addr_i = 32'h300; req1_enable_i = 1'b0;
    repeat (3) cycle();
    check("t_hold_addr", mem_addr_o, 32'h200);
    check("t_hold_grant", grant_o, 2'b10);
    serve(2, rand256());

    // Stray ack in DONE, then in IDLE.
    mem_ack_i = 1'b1; cycle();
    mem_ack_i = 1'b1; cycle();
    mem_ack_i = 1'b0; cycle();

    // Reset three cycles into a grant, then a normal port-0 transaction.
    req0_enable_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h440;
    wait_grant();
    repeat (3) cycle();
    pulse_reset();
    wait_grant();
    check("t_post_rst", grant_o, 2'b01);
    serve(3, pat_a);
    req0_enable_i = 1'b0;

    // Random traffic with random latency, stray acks, early drops, rare resets.
    repeat (3000) begin
      rst_i = ($urandom_range(0, 299) != 0);
      mem_ack_i = ($urandom_range(0, 3) == 0);
      mem_data_i = rand256();
      if (!req0_enable_i) begin
        if ($urandom_range(0, 2) == 0) begin
          req0_enable_i = 1'b1; req0_write_i = 1'($urandom);
          req0_addr_i = $urandom; req0_data_i = rand256();
        end
      end else if (acked0 || $urandom_range(0, 15) == 0) begin
        req0_enable_i = 1'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req0_addr_i = $urandom; req0_data_i = rand256();
      end
      if (!req1_enable_i) begin
        if ($urandom_range(0, 2) == 0) begin
          req1_enable_i = 1'b1; req1_write_i = 1'($urandom);
          req1_addr_i = $urandom; req1_data_i = rand256();
        end
      end else if (acked1 || $urandom_range(0, 15) == 0) begin
        req1_enable_i = 1'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req1_addr_i = $urandom; req1_data_i = rand256();
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing the single 256-bit main-memory interface between the instruction-cache controller (port 0) and the data-cache controller (port 1). It sits between both cache controllers and Data_Memory. It latches the winning request, holds it on the memory bus until `mem_ack_i`, and routes the ack and read data back to the granted requester only.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 256, cache-line width.

- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset; asynchronous, active-low.
- `req0_enable_i` in 1: port 0 (icache) request; held high until `req0_ack_o`.
- `req0_write_i` in 1: port 0 write (1) / read (0).
- `req0_addr_i` in ADDR_W: port 0 line address.
- `req0_data_i` in DATA_W: port 0 write data.
- `req0_ack_o` out 1: port 0 transaction complete.
- `req0_data_o` out DATA_W: port 0 read data.
- `req1_*`: same six signals for port 1 (dcache).
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: memory write.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_data_o` out DATA_W: memory write data.
- `mem_ack_i` in 1: memory completion.
- `mem_data_i` in DATA_W: memory read data.
- `grant_o` out 2: one-hot current owner; 00 when idle.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE: at least one request is present → GRANT0 or GRANT1 by arbitration; otherwise stay.
  - GRANT0 or GRANT1: `mem_ack_i` → DONE.
  - DONE: → IDLE unconditionally.
- Arbitration, evaluated in IDLE only:
  - A single requester wins.
  - If both request, the port that is not `last_q` wins.
  - `last_q` updates to the winner on entry to GRANTx.
  - `last_q` resets to 0, so port 1 wins the first contention.
- On entry to GRANTx, the arbiter registers the winner's write, addr and data into `mem_write_o`, `mem_addr_o` and `mem_data_o`. These stay stable for the whole grant, even if the requester's inputs change.
- `mem_enable_o` is registered: 1 in GRANTx, 0 in IDLE and DONE.
- Ack routing (combinational):
  - `reqX_ack_o` = `mem_ack_i` AND state==GRANTX.
  - `reqX_data_o` = `mem_data_i` when `reqX_ack_o`, else 0.
  - The non-granted port sees ack 0 and data 0.
- DONE is a one-cycle bubble that lets the served requester drop its enable. Requests are not sampled in DONE.
- `mem_ack_i` in IDLE or DONE is ignored: no state change, no ack routed.
- A requester dropping enable before its ack does not abort the transaction. The grant holds until `mem_ack_i`.
- Write transactions return `reqX_data_o` = `mem_data_i` like reads; the requester ignores it.
- Reset (asynchronous, any state):
  - state → IDLE, `last_q` → 0.
  - `mem_enable_o`, `mem_write_o`, `mem_addr_o`, `mem_data_o`, `grant_o`, `busy_o` → 0.
  - All ack/data outputs → 0.
  - An in-flight memory transaction is abandoned.

## Timing
- Request present in IDLE at edge N → `mem_enable_o`, `grant_o` and `busy_o` high from cycle N+1. Grant latency is 1 cycle.
- `mem_ack_i` high in cycle M → `reqX_ack_o` high in the same cycle M. `mem_enable_o` low from M+1 (DONE), IDLE at M+2.
- Minimum turnaround between back-to-back grants is 2 cycles after ack. With Data_Memory latency L, one transaction occupies L+2 cycles.
- With both ports continuously requesting, grants alternate strictly 1,0,1,0…; neither port waits more than one transaction.
- `grant_o` and `busy_o` are registered, derived from state, and glitch-free.

## Test plan
- Reset: hold `rst_i`=0 with random inputs → all outputs 0. Release, no requests → IDLE, `mem_enable_o`=0 indefinitely.
- Single read on port 0 (addr 0x0000_0400), memory acks after 10 cycles with data pattern A:
  - `mem_enable_o` rises 1 cycle after the request, `mem_addr_o`=0x400, `mem_write_o`=0.
  - `req0_ack_o` pulses with `req0_data_o`=A; `req1_ack_o` stays 0.
  - `mem_enable_o` falls the next cycle.
- Simultaneous first requests (port0 read 0x100, port1 write 0x200, data B):
  - Port 1 granted first with `mem_data_o`=B.
  - Port 0 granted 2 cycles after port 1's ack.
  - Four back-to-back contended transactions grant 1,0,1,0.
- Input change mid-grant: port 1 changes `req1_addr_i` to 0x300 and drops enable while granted → `mem_addr_o` stays 0x200 and the grant holds until `mem_ack_i`.
- Stray `mem_ack_i` pulse in IDLE and in DONE → no state change; both `reqX_ack_o` stay 0.
- Reset asserted 3 cycles into a grant → outputs 0 immediately. After release, a port 0 request is granted normally.
